gmii_rx_frame: RTL



---
 rtl/eth_rx_pkg.sv | 36 +++
 rtl/crc32_d8.sv | 27 ++
 rtl/gmii_rx_frame.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared constants and types for the GMII receive framer.
//   - Preamble / SFD byte values.
//   - CRC-32 init, polynomial (normal form) and good-frame residue.
//   - Bit positions inside the per-frame status word.
//   - Receive FSM state encoding.
package eth_rx_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
    // Register value (no final XOR) after running the CRC over data plus a correct FCS.
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

    localparam int unsigned STAT_CRC_BAD   = 0;
    localparam int unsigned STAT_ADDR_MISS = 1;
    localparam int unsigned STAT_LEN_ERR   = 2;

    typedef enum logic [1:0] {
        DROP,
        IDLE,
        PREAMBLE,
        DATA
    } rx_state_e;

    // Bit-reverse a 32-bit word; turns the normal-form polynomial into the LSB-first form.
    function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: combinational next-state of the Ethernet CRC-32 for one data byte.
//   Reflected (LSB-first) algorithm, no final XOR.
//   crc_in  [31:0] current CRC register
//   data    [7:0]  received byte, bit 0 is the first bit on the wire
//   crc_out [31:0] CRC register after absorbing data
module crc32_d8
    import eth_rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_REFL = bit_reverse32(CRC_POLY);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_out[0] ^ data[i]) begin
                crc_out = (crc_out >> 1) ^ POLY_REFL;
            end else begin
                crc_out = crc_out >> 1;
            end
        end
    end

endmodule

// File: rtl/gmii_rx_frame.sv
// gmii_rx_frame: byte-level Ethernet receive framer on the GMII side.
//   Strips preamble/SFD, hides the 4-byte FCS behind a 5-deep delay line, checks CRC-32,
//   destination MAC and frame length, and counts good/bad frames.
//   gmii_rx_clk  sole clock
//   rst_n        synchronous reset, active low
//   gmii_rx_dv   GMII data valid
//   gmii_rxd     GMII data byte
//   rx_data      frame byte (dst MAC through payload)
//   rx_valid     rx_data valid, one cycle per byte
//   rx_sop       first byte of frame
//   rx_eop       last non-FCS byte of frame
//   rx_status    with rx_eop: [0] crc_bad, [1] addr_miss, [2] len_err
//   rx_good_cnt  frames ending with status 0 (wraps)
//   rx_bad_cnt   frames ending with nonzero status, plus aborted short frames (wraps)
module gmii_rx_frame
    import eth_rx_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC      = 48'h00_11_22_33_44_55,
    parameter bit          ADDR_FILTER_EN = 1'b1,
    parameter int unsigned MIN_LEN        = 64,
    parameter int unsigned MAX_LEN        = 1522
) (
    input  logic        gmii_rx_clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sop,
    output logic        rx_eop,
    output logic [2:0]  rx_status,
    output logic [15:0] rx_good_cnt,
    output logic [15:0] rx_bad_cnt
);

    rx_state_e   state_q;
    logic [2:0]  pcnt_q;
    logic [15:0] n_q;          // frame bytes received since SFD
    logic [31:0] crc_q;
    logic [7:0]  dl_q [5];     // dl_q[0] newest, dl_q[4] oldest
    logic        hit_local_q;
    logic        hit_bcast_q;

    logic [31:0] crc_next;
    logic [7:0]  mac_byte;
    logic        addr_miss;
    logic [2:0]  eop_status;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (gmii_rxd),
        .crc_out (crc_next)
    );

    // Station address byte expected at the current destination-field position.
    always_comb begin
        mac_byte = 8'h00;
        case (n_q[2:0])
            3'd0:    mac_byte = LOCAL_MAC[47:40];
            3'd1:    mac_byte = LOCAL_MAC[39:32];
            3'd2:    mac_byte = LOCAL_MAC[31:24];
            3'd3:    mac_byte = LOCAL_MAC[23:16];
            3'd4:    mac_byte = LOCAL_MAC[15:8];
            3'd5:    mac_byte = LOCAL_MAC[7:0];
            default: mac_byte = 8'h00;
        endcase
    end

    // Frames shorter than a full destination field never match.
    assign addr_miss = ADDR_FILTER_EN && !((n_q >= 16'd6) && (hit_local_q || hit_bcast_q));

    always_comb begin
        eop_status                 = 3'b000;
        eop_status[STAT_CRC_BAD]   = (crc_q != CRC_RESIDUE);
        eop_status[STAT_ADDR_MISS] = addr_miss;
        eop_status[STAT_LEN_ERR]   = (n_q < 16'(MIN_LEN));
    end

    always_ff @(posedge gmii_rx_clk) begin
        if (!rst_n) begin
            state_q     <= DROP;
            pcnt_q      <= 3'd0;
            n_q         <= 16'd0;
            crc_q       <= CRC_INIT;
            hit_local_q <= 1'b0;
            hit_bcast_q <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                dl_q[i] <= 8'h00;
            end
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            rx_sop      <= 1'b0;
            rx_eop      <= 1'b0;
            rx_status   <= 3'b000;
            rx_good_cnt <= 16'd0;
            rx_bad_cnt  <= 16'd0;
        end else begin
            rx_valid  <= 1'b0;
            rx_sop    <= 1'b0;
            rx_eop    <= 1'b0;
            rx_status <= 3'b000;

            unique case (state_q)
                DROP: begin
                    if (!gmii_rx_dv) begin
                        state_q <= IDLE;
                    end
                end

                IDLE: begin
                    if (gmii_rx_dv) begin
                        if (gmii_rxd == PREAMBLE_BYTE) begin
                            state_q <= PREAMBLE;
                            pcnt_q  <= 3'd1;
                        end else begin
                            state_q <= DROP;
                        end
                    end
                end

                PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        state_q <= IDLE;
                    end else if (gmii_rxd == PREAMBLE_BYTE) begin
                        if (pcnt_q == 3'd7) begin
                            state_q <= DROP;
                        end else begin
                            pcnt_q <= pcnt_q + 3'd1;
                        end
                    end else if (gmii_rxd == SFD_BYTE) begin
                        state_q     <= DATA;
                        n_q         <= 16'd0;
                        crc_q       <= CRC_INIT;
                        hit_local_q <= 1'b1;
                        hit_bcast_q <= 1'b1;
                    end else begin
                        state_q <= DROP;
                    end
                end

                DATA: begin
                    if (!gmii_rx_dv) begin
                        // End of frame: the oldest delay-line byte is the last non-FCS byte.
                        state_q <= IDLE;
                        if (n_q >= 16'd5) begin
                            rx_data   <= dl_q[4];
                            rx_valid  <= 1'b1;
                            rx_sop    <= (n_q == 16'd5);
                            rx_eop    <= 1'b1;
                            rx_status <= eop_status;
                            if (eop_status == 3'b000) begin
                                rx_good_cnt <= rx_good_cnt + 16'd1;
                            end else begin
                                rx_bad_cnt <= rx_bad_cnt + 16'd1;
                            end
                        end else begin
                            rx_bad_cnt <= rx_bad_cnt + 16'd1;
                        end
                    end else if (n_q == 16'(MAX_LEN)) begin
                        // Oversize: close the frame on the pending byte and drop the rest.
                        state_q                   <= DROP;
                        rx_data                   <= dl_q[4];
                        rx_valid                  <= 1'b1;
                        rx_sop                    <= (n_q == 16'd5);
                        rx_eop                    <= 1'b1;
                        rx_status[STAT_CRC_BAD]   <= 1'b1;
                        rx_status[STAT_ADDR_MISS] <= addr_miss;
                        rx_status[STAT_LEN_ERR]   <= 1'b1;
                        rx_bad_cnt                <= rx_bad_cnt + 16'd1;
                    end else begin
                        if (n_q >= 16'd5) begin
                            rx_data  <= dl_q[4];
                            rx_valid <= 1'b1;
                            rx_sop   <= (n_q == 16'd5);
                        end
                        dl_q[0] <= gmii_rxd;
                        for (int i = 1; i < 5; i++) begin
                            dl_q[i] <= dl_q[i-1];
                        end
                        crc_q <= crc_next;
                        n_q   <= n_q + 16'd1;
                        if (n_q < 16'd6) begin
                            hit_local_q <= hit_local_q && (gmii_rxd == mac_byte);
                            hit_bcast_q <= hit_bcast_q && (gmii_rxd == 8'hFF);
                        end
                    end
                end

                default: state_q <= DROP;
            endcase
        end
    end

endmodule
